// File: rtl/jpu_exc_unit.sv
// -----------------------------------------------------------------------------
// jpu_exc_unit
// CP0-style exception / interrupt controller for the jpu core. It sits beside
// the commit stage and does the following:
//   - picks the highest-priority exception flag of the committing instruction,
//     or a pending unmasked interrupt;
//   - records EPC, BadVAddr and Cause;
//   - issues a one-cycle redirect to the handler vector, or back to EPC on ERET;
//   - owns the periodic system timer and the MTC0/MFC0 register file.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   valid_i          committing instruction valid
//   exc_i[10:0]      exception flags (bit10 AdEL ... bit0 FPE)
//   pc_i, badaddr_i  PC and faulting address of committing instruction
//   eret_i           committing instruction is ERET
//   hw_irq_i[4:0]    level hardware interrupt lines
//   cp0_we_i, cp0_addr_i, cp0_wdata_i   MTC0 port (address shared with MFC0)
//   cp0_rdata_o      MFC0 data, combinational from cp0_addr_i
//   redirect_o, redirect_pc_o           registered pipeline redirect
//   exl_o            Status.EXL (handler mode)
// -----------------------------------------------------------------------------
module jpu_exc_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter logic [15:0] TIMER_PERIOD = 16'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [10:0] exc_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badaddr_i,
  input  logic        eret_i,
  input  logic [4:0]  hw_irq_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_addr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] cp0_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        exl_o
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  // Priority encoder: highest-priority flag wins; result is the ExcCode.
  function automatic logic [4:0] exc_code_f(input logic [10:0] exc);
    logic [4:0] code;
    code = 5'd0;
    casez (exc)
      11'b1??_????_????: code = 5'd4;   // AdEL
      11'b01?_????_????: code = 5'd5;   // AdES
      11'b001_????_????: code = 5'd6;   // IBE
      11'b000_1???_????: code = 5'd7;   // DBE
      11'b000_01??_????: code = 5'd8;   // Sys
      11'b000_001?_????: code = 5'd9;   // Bp
      11'b000_0001_????: code = 5'd10;  // RI
      11'b000_0000_1???: code = 5'd11;  // CpU
      11'b000_0000_01??: code = 5'd12;  // Ov
      11'b000_0000_001?: code = 5'd13;  // Tr
      11'b000_0000_0001: code = 5'd15;  // FPE
      default:           code = 5'd0;
    endcase
    return code;
  endfunction

  logic [15:0] timer_cnt_r;
  logic        timer_pend_r;
  logic [7:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic [1:0]  ip_sw_r;
  logic [4:0]  exccode_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic        redirect_r;
  logic [31:0] redirect_pc_r;

  logic [7:0]  ip_s;
  logic        tick_s;
  logic        exc_take_s;
  logic        int_take_s;
  logic        take_s;
  logic        eret_take_s;
  logic        mtc0_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;
  logic        badv_upd_s;
  logic [4:0]  exc_code_s;
  logic [31:0] rdata_s;

  assign ip_s       = {timer_pend_r, hw_irq_i, ip_sw_r};
  assign tick_s     = (timer_cnt_r == 16'd0);
  assign exc_code_s = exc_code_f(exc_i);
  assign exc_take_s = valid_i & (|exc_i);
  assign int_take_s = valid_i & ~exc_take_s & ie_r & ~exl_r & (|(ip_s & im_r));
  assign take_s     = exc_take_s | int_take_s;
  // A taken interrupt also suppresses ERET so only one redirect target exists;
  // in practice ERET runs in handler mode where interrupts are masked anyway.
  assign eret_take_s = valid_i & eret_i & ~take_s;
  assign mtc0_s      = valid_i & cp0_we_i & ~take_s;
  assign wr_status_s = mtc0_s & (cp0_addr_i == ADDR_STATUS);
  assign wr_cause_s  = mtc0_s & (cp0_addr_i == ADDR_CAUSE);
  assign wr_epc_s    = mtc0_s & (cp0_addr_i == ADDR_EPC);
  assign badv_upd_s  = exc_take_s & (exc_i[10] | exc_i[9]);

  // MFC0 read mux; unmapped registers read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (cp0_addr_i)
      ADDR_BADVADDR: rdata_s = badvaddr_r;
      ADDR_STATUS:   rdata_s = {16'd0, im_r, 6'd0, exl_r, ie_r};
      ADDR_CAUSE:    rdata_s = {16'd0, ip_s, 1'b0, exccode_r, 2'd0};
      ADDR_EPC:      rdata_s = epc_r;
      default:       rdata_s = 32'd0;
    endcase
  end

  assign cp0_rdata_o = rdata_s;

  // System timer down-counter: reloads on reaching zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_cnt_r <= TIMER_PERIOD - 16'd1;
    end else if (tick_s) begin
      timer_cnt_r <= TIMER_PERIOD - 16'd1;
    end else begin
      timer_cnt_r <= timer_cnt_r - 16'd1;
    end
  end

  // Sticky timer-pending bit; a tick beats a coincident Cause write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_pend_r <= 1'b0;
    end else if (tick_s) begin
      timer_pend_r <= 1'b1;
    end else if (wr_cause_s) begin
      timer_pend_r <= 1'b0;
    end else begin
      timer_pend_r <= timer_pend_r;
    end
  end

  // Status register: IM/IE via MTC0; EXL set on take, cleared by ERET
  // (ERET overrides an EXL value written by a simultaneous MTC0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_r  <= 8'd0;
      ie_r  <= 1'b0;
      exl_r <= 1'b0;
    end else begin
      if (wr_status_s) begin
        im_r <= cp0_wdata_i[15:8];
        ie_r <= cp0_wdata_i[0];
      end else begin
        im_r <= im_r;
        ie_r <= ie_r;
      end
      if (take_s) begin
        exl_r <= 1'b1;
      end else if (eret_take_s) begin
        exl_r <= 1'b0;
      end else if (wr_status_s) begin
        exl_r <= cp0_wdata_i[1];
      end else begin
        exl_r <= exl_r;
      end
    end
  end

  // Cause register: ExcCode on take, software IP bits via MTC0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exccode_r <= 5'd0;
      ip_sw_r   <= 2'd0;
    end else begin
      if (take_s) begin
        exccode_r <= exc_take_s ? exc_code_s : 5'd0;
      end else begin
        exccode_r <= exccode_r;
      end
      if (wr_cause_s) begin
        ip_sw_r <= cp0_wdata_i[9:8];
      end else begin
        ip_sw_r <= ip_sw_r;
      end
    end
  end

  // EPC: captured on a non-nested take, otherwise writable by MTC0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_r <= 32'd0;
    end else if (take_s && !exl_r) begin
      epc_r <= pc_i;
    end else if (wr_epc_s) begin
      epc_r <= cp0_wdata_i;
    end else begin
      epc_r <= epc_r;
    end
  end

  // BadVAddr: captured only for address-error exceptions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      badvaddr_r <= 32'd0;
    end else if (badv_upd_s) begin
      badvaddr_r <= badaddr_i;
    end else begin
      badvaddr_r <= badvaddr_r;
    end
  end

  // Redirect pulse and held target; ERET returns to the pre-write EPC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_r    <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      redirect_r <= take_s | eret_take_s;
      if (take_s) begin
        redirect_pc_r <= EXC_VECTOR;
      end else if (eret_take_s) begin
        redirect_pc_r <= epc_r;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

  assign redirect_o    = redirect_r;
  assign redirect_pc_o = redirect_pc_r;
  assign exl_o         = exl_r;

endmodule
